// File: rtl/pmem_load_pkg.sv
// Shared types and sizing for the program-memory boot loader.
// The optional PMEM_LOAD_CHKSUM_EN build uses the CHECK state.
package pmem_load_pkg;

   localparam int PMEM_DEPTH = 512;
   localparam int PMEM_AW    = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } ld_state_t;

   // A load length is usable only when it names at least one word and fits the memory.
   function automatic logic len_ok(input logic [31:0] len, input logic [31:0] depth);
      return (len != 32'd0) && (len <= depth);
   endfunction

endpackage

// File: rtl/pmem_load_chksum.sv
// Running 32-bit wrapping sum of accepted host words, compared against the expected value
// captured with start. Only instantiated when PMEM_LOAD_CHKSUM_EN is defined.
module pmem_load_chksum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        add,
   input  logic [31:0] data,
   input  logic [31:0] exp_in,
   output logic        match
);

   logic [31:0] sum;
   logic [31:0] exp_val;

   // Accumulator restarts and captures the expected sum on every accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum     <= 32'd0;
         exp_val <= 32'd0;
      end else if (clear) begin
         sum     <= 32'd0;
         exp_val <= exp_in;
      end else if (add) begin
         sum     <= sum + data;
      end
   end

   assign match = (sum == exp_val);

endmodule

// File: rtl/pmem_load_ctrl.sv
// Boot loader: streams host words into PMEM at incrementing addresses and holds the core
// in reset until the image is complete. Optional checksum gate: PMEM_LOAD_CHKSUM_EN.
module pmem_load_ctrl
   import pmem_load_pkg::*;
#(
   parameter int DEPTH = PMEM_DEPTH,
   parameter int AW    = PMEM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   load_len,
   input  logic          abort,
   input  logic          host_valid,
   input  logic [31:0]   host_data,
`ifdef PMEM_LOAD_CHKSUM_EN
   input  logic [31:0]   chk_exp,
   output logic          chk_ok,
`endif
   output logic          host_ready,
   output logic          pmem_wr_valid,
   output logic [31:0]   pmem_wr_addr,
   output logic [31:0]   pmem_wr_data,
   output logic          core_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_cnt
);

   ld_state_t   state;
   ld_state_t   state_nxt;
   logic [AW:0] len;
   logic [AW:0] cnt_inc;
   logic        start_idle;
   logic        accept;
   logic        reject;
   logic        xfer;
   logic        last;

`ifdef PMEM_LOAD_CHKSUM_EN
   logic        chk_match;

   pmem_load_chksum u_chksum (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .add    (xfer),
      .data   (host_data),
      .exp_in (chk_exp),
      .match  (chk_match)
   );
`endif

   // State-derived outputs and handshake qualifiers; abort discards a same-cycle transfer.
   always_comb begin
      host_ready = (state == LOAD);
      done       = (state == DONE);
      core_hold  = (state != DONE);
      start_idle = start && ((state == IDLE) || (state == DONE));
      accept     = start_idle && len_ok(32'(load_len), 32'(DEPTH));
      reject     = start_idle && !len_ok(32'(load_len), 32'(DEPTH));
      xfer       = (state == LOAD) && host_valid && !abort;
      cnt_inc    = word_cnt + {{AW{1'b0}}, 1'b1};
      last       = xfer && (cnt_inc == len);
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = LOAD;
            else        state_nxt = IDLE;
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (last) begin
`ifdef PMEM_LOAD_CHKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = LOAD;
            end
         end
         CHECK: begin
`ifdef PMEM_LOAD_CHKSUM_EN
            if (chk_match) state_nxt = DONE;
            else           state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         DONE: begin
            if (accept) state_nxt = LOAD;
            else        state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM, counter, error flag and the write channel, which lags its handshake by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         len           <= {(AW+1){1'b0}};
         word_cnt      <= {(AW+1){1'b0}};
         err           <= 1'b0;
         pmem_wr_valid <= 1'b0;
         pmem_wr_addr  <= 32'd0;
         pmem_wr_data  <= 32'd0;
      end else begin
         state         <= state_nxt;
         pmem_wr_valid <= xfer;
         if (accept) begin
            len      <= load_len;
            word_cnt <= {(AW+1){1'b0}};
         end else if (xfer) begin
            word_cnt <= cnt_inc;
         end
         if (xfer) begin
            pmem_wr_addr <= {{(31-AW){1'b0}}, word_cnt};
            pmem_wr_data <= host_data;
         end
         if (accept) begin
            err <= 1'b0;
         end else if (reject || ((state == LOAD) && abort)) begin
            err <= 1'b1;
`ifdef PMEM_LOAD_CHKSUM_EN
         end else if ((state == CHECK) && !chk_match) begin
            err <= 1'b1;
`endif
         end
      end
   end

`ifdef PMEM_LOAD_CHKSUM_EN
   // Checksum verdict is latched on leaving CHECK and cleared by the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_ok <= 1'b0;
      end else if (accept) begin
         chk_ok <= 1'b0;
      end else if (state == CHECK) begin
         chk_ok <= chk_match;
      end
   end
`endif

endmodule

// File: tb/tb_pmem_load_ctrl.sv
// Self-checking bench for pmem_load_ctrl: cycle-level reference model plus boundary table
// and hand-written corner sequences (abort, reload, async reset, optional checksum).
module tb_pmem_load_ctrl;
   import pmem_load_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        host_valid = 1'b0;
   logic [9:0]  load_len = 10'd0;
   logic [31:0] host_data = 32'd0;
   logic        host_ready, pmem_wr_valid, core_hold, done, err;
   logic [31:0] pmem_wr_addr, pmem_wr_data;
   logic [9:0]  word_cnt;
`ifdef PMEM_LOAD_CHKSUM_EN
   logic [31:0] chk_exp = 32'd0;
   logic        chk_ok;
`endif

   int errors = 0;
   int checks = 0;
   int wr_seen = 0;
   logic [31:0] last_addr = 32'd0;

   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2, PH_CHECK = 3;
   int          m_phase, m_len, m_cnt;
   bit          m_err, m_wv, m_ok;
   logic [31:0] m_wa, m_wd, m_sum, m_exp;

   typedef struct {
      logic [9:0] len;
      bit         accept;
   } vec_t;
   vec_t tbl[6];

   pmem_load_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .load_len      (load_len),
      .abort         (abort),
      .host_valid    (host_valid),
      .host_data     (host_data),
`ifdef PMEM_LOAD_CHKSUM_EN
      .chk_exp       (chk_exp),
      .chk_ok        (chk_ok),
`endif
      .host_ready    (host_ready),
      .pmem_wr_valid (pmem_wr_valid),
      .pmem_wr_addr  (pmem_wr_addr),
      .pmem_wr_data  (pmem_wr_data),
      .core_hold     (core_hold),
      .done          (done),
      .err           (err),
      .word_cnt      (word_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE; m_len = 0; m_cnt = 0; m_err = 1'b0; m_wv = 1'b0; m_ok = 1'b0;
      m_wa = 32'd0; m_wd = 32'd0; m_sum = 32'd0; m_exp = 32'd0;
   endtask

   // One clock edge of the loader as described in words: what the edge does to the image.
   task automatic model_step();
      m_wv = 1'b0;
      case (m_phase)
         PH_LOAD: begin
            if (abort) begin
               m_phase = PH_IDLE;
               m_err   = 1'b1;
            end else if (host_valid) begin
               m_wv  = 1'b1;
               m_wa  = 32'(m_cnt);
               m_wd  = host_data;
               m_sum = m_sum + host_data;
               m_cnt = m_cnt + 1;
`ifdef PMEM_LOAD_CHKSUM_EN
               if (m_cnt == m_len) m_phase = PH_CHECK;
`else
               if (m_cnt == m_len) m_phase = PH_DONE;
`endif
            end
         end
         PH_CHECK: begin
            if (m_sum == m_exp) begin
               m_phase = PH_DONE;
               m_ok    = 1'b1;
            end else begin
               m_phase = PH_IDLE;
               m_err   = 1'b1;
               m_ok    = 1'b0;
            end
         end
         default: begin
            if (start) begin
               if (load_len >= 10'd1 && load_len <= 10'd512) begin
                  m_phase = PH_LOAD;
                  m_len   = int'(load_len);
                  m_cnt   = 0;
                  m_err   = 1'b0;
                  m_sum   = 32'd0;
                  m_ok    = 1'b0;
`ifdef PMEM_LOAD_CHKSUM_EN
                  m_exp   = chk_exp;
`endif
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      chk("host_ready", 32'(host_ready), 32'(m_phase == PH_LOAD));
      chk("wr_valid", 32'(pmem_wr_valid), 32'(m_wv));
      chk("wr_addr", pmem_wr_addr, m_wa);
      chk("wr_data", pmem_wr_data, m_wd);
      chk("core_hold", 32'(core_hold), 32'(m_phase != PH_DONE));
      chk("done", 32'(done), 32'(m_phase == PH_DONE));
      chk("err", 32'(err), 32'(m_err));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
`ifdef PMEM_LOAD_CHKSUM_EN
      chk("chk_ok", 32'(chk_ok), 32'(m_ok));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (pmem_wr_valid === 1'b1) begin
         wr_seen++;
         last_addr = pmem_wr_addr;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; host_valid = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      compare_all();
      rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [9:0] len);
      start = 1'b1;
      load_len = len;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int n, input logic [31:0] base, input logic [31:0] stp);
      for (int i = 0; i < n; i++) begin
         host_valid = 1'b1;
         host_data  = base + stp * 32'(i);
         tick();
      end
      host_valid = 1'b0;
   endtask

   initial begin
      int n;
      tbl[0] = '{10'd0,    1'b0};
      tbl[1] = '{10'd513,  1'b0};
      tbl[2] = '{10'd1023, 1'b0};
      tbl[3] = '{10'd1,    1'b1};
      tbl[4] = '{10'd512,  1'b1};
      tbl[5] = '{10'd2,    1'b1};

      // Reset and idle: host traffic without start must not write.
      do_reset();
      chk("rst_core_hold", 32'(core_hold), 32'd1);
      chk("rst_host_ready", 32'(host_ready), 32'd0);
      wr_seen = 0;
      host_valid = 1'b1; host_data = 32'hDEADBEEF;
      repeat (3) tick();
      host_valid = 1'b0;
      chk("idle_no_write", 32'(wr_seen), 32'd0);

      // Basic four-word load.
      pulse_start(10'd4);
      feed(4, 32'h11111111, 32'h11111111);
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_release", 32'(core_hold), 32'd0);
      chk("basic_last_valid", 32'(pmem_wr_valid), 32'd1);
      chk("basic_last_addr", pmem_wr_addr, 32'd3);
      chk("basic_last_data", pmem_wr_data, 32'h44444444);
      chk("basic_word_cnt", 32'(word_cnt), 32'd4);
      tick();
      chk("basic_no_extra", 32'(pmem_wr_valid), 32'd0);

      // Reload from DONE: hold returns on the very next cycle.
      pulse_start(10'd2);
      chk("reload_hold", 32'(core_hold), 32'd1);
      chk("reload_done_clr", 32'(done), 32'd0);
      feed(2, $urandom, $urandom);
      chk("reload_done", 32'(done), 32'd1);

      // Abort together with the third transfer.
      pulse_start(10'd8);
      wr_seen = 0;
      host_valid = 1'b1; host_data = $urandom; tick();
      host_data = $urandom; tick();
      host_data = $urandom; abort = 1'b1; tick();
      abort = 1'b0; host_valid = 1'b0; tick();
      chk("abort_writes", 32'(wr_seen), 32'd2);
      chk("abort_last_addr", last_addr, 32'd1);
      chk("abort_err", 32'(err), 32'd1);
      chk("abort_hold", 32'(core_hold), 32'd1);
      pulse_start(10'd3);
      chk("restart_err_clr", 32'(err), 32'd0);
      wr_seen = 0;
      feed(3, $urandom, 32'd7);
      chk("restart_writes", 32'(wr_seen), 32'd3);
      chk("restart_last", last_addr, 32'd2);

      // Full-depth load with a throttled host.
      pulse_start(10'd512);
      wr_seen = 0;
      n = 0;
      while (done !== 1'b1 && n < 5000) begin
         host_valid = 1'($urandom_range(0, 1));
         host_data  = $urandom;
         tick();
         n++;
      end
      host_valid = 1'b0;
      chk("full_timeout", 32'(n < 5000), 32'd1);
      chk("full_writes", 32'(wr_seen), 32'd512);
      chk("full_last_addr", last_addr, 32'd511);
      tick();
      chk("full_no_wrap", 32'(wr_seen), 32'd512);

      // Length boundaries from IDLE.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         pulse_start(tbl[i].len);
         chk("len_err", 32'(err), 32'(!tbl[i].accept));
         chk("len_ready", 32'(host_ready), 32'(tbl[i].accept));
         if (tbl[i].accept) begin
            abort = 1'b1; tick(); abort = 1'b0;
         end
      end

      // Asynchronous reset in the middle of a load.
      pulse_start(10'd8);
      host_valid = 1'b1;
      repeat (3) begin host_data = $urandom; tick(); end
      #2 rst = 1'b1;
      #1;
      chk("arst_hold", 32'(core_hold), 32'd1);
      chk("arst_wr_valid", 32'(pmem_wr_valid), 32'd0);
      chk("arst_ready", 32'(host_ready), 32'd0);
      host_valid = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      tick();

`ifdef PMEM_LOAD_CHKSUM_EN
      // Checksum gate: matching and mismatching expected sums.
      chk_exp = 32'd6;
      pulse_start(10'd3);
      feed(3, 32'd1, 32'd1);
      chk("chk_in_check_hold", 32'(core_hold), 32'd1);
      tick();
      chk("chk_pass_ok", 32'(chk_ok), 32'd1);
      chk("chk_pass_done", 32'(done), 32'd1);
      chk_exp = 32'd7;
      pulse_start(10'd3);
      feed(3, 32'd1, 32'd1);
      tick();
      chk("chk_fail_err", 32'(err), 32'd1);
      chk("chk_fail_hold", 32'(core_hold), 32'd1);
      chk("chk_fail_ok", 32'(chk_ok), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
